fx_match_pipe: RTL and testbench

Parametrised, pipelined fixed-point format converter. It takes a signed fixed-point sample of IW bits with IF fractional bits and re-quantises it to OW bits with OF fractional bits. Quantisation mode and overflow mode are selectable per sample, and a valid/ready handshake with back-pressure is provided. It is the generalised successor of the fixed truncate-and-wrap match-plus-delay blocks, and sits between arithmetic datapath stages wherever word formats change.

---
 rtl/fx_match_pipe_if.sv | 33 +++
 rtl/fx_match_pipe.sv | 130 +++++++++++++
 tb/tb_fx_match_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fx_match_pipe_if.sv
// fx_match_pipe_if: sample stream bundle for fx_match_pipe.
//   slave  - converter side: takes i_* (sample, modes, downstream ready,
//            counter clear), drives o_* (ready, converted sample, ovf, count).
//   master - producer/consumer side, the mirror image.
// Signal names keep the i_/o_ prefixes of the converter's original port list
// so existing integration scripts still match.
interface fx_match_pipe_if #(
  parameter int IW   = 17,
  parameter int OW   = 12,
  parameter int CNTW = 16
);
  logic [IW-1:0]   i_data;
  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_qmode;
  logic            i_omode;
  logic [OW-1:0]   o_data;
  logic            o_valid;
  logic            i_ready;
  logic            o_ovf;
  logic [CNTW-1:0] o_ovf_cnt;
  logic            i_clr;

  modport slave (
    input  i_data, i_valid, i_qmode, i_omode, i_ready, i_clr,
    output o_ready, o_data, o_valid, o_ovf, o_ovf_cnt
  );

  modport master (
    output i_data, i_valid, i_qmode, i_omode, i_ready, i_clr,
    input  o_ready, o_data, o_valid, o_ovf, o_ovf_cnt
  );
endinterface

// File: rtl/fx_match_pipe.sv
// fx_match_pipe: pipelined signed fixed-point re-quantiser.
// Converts IW-bit samples with IF fraction bits to OW bits with OF fraction
// bits. Quantisation (trunc / round-half-up / convergent) and overflow
// (wrap / saturate) modes travel with each sample.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset, flushes the pipe
//   bus    - fx_match_pipe_if.slave: valid/ready sample in, valid/ready
//            sample out, per-sample modes, o_ovf flag, overflow counter
// Optional feature: define FX_MATCH_OVF_CNT_EN to build the saturating
// overflow event counter; otherwise o_ovf_cnt is 0 and i_clr is ignored.
module fx_match_pipe #(
  parameter int IW    = 17,
  parameter int IF    = 2,
  parameter int OW    = 12,
  parameter int OF    = 0,
  parameter int DELAY = 1,
  parameter int CNTW  = 16
) (
  input logic            i_clk,
  input logic            i_rst,
  fx_match_pipe_if.slave bus
);
  localparam int SH = IF - OF;
  localparam int QW = IW - SH + 1;           // width of quantised value
  localparam int EW = (QW > OW) ? QW : OW;   // common width for range check

  localparam logic [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};
  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};

  typedef struct packed {
    logic [OW-1:0] data;
    logic          ovf;
  } stage_t;

  if (DELAY < 1) begin : g_bad_delay
    $error("fx_match_pipe: DELAY must be >= 1");
  end

  // ---- quantisation ----
  logic signed [QW-1:0] q;

  if (SH < 0) begin : g_bad_sh
    $error("fx_match_pipe: IF must be >= OF");
  end else if (SH == 0) begin : g_noq
    logic unused_qmode;
    assign unused_qmode = ^bus.i_qmode;
    assign q = {bus.i_data[IW-1], bus.i_data};
  end else begin : g_q
    localparam logic [SH-1:0] HALF = SH'(1) << (SH-1);
    logic signed [IW:0]  xe, sum;
    logic [QW-1:0]       q_fl, q_up;
    logic                tie;
    logic                unused_lo;

    // One guard bit keeps x + half from overflowing.
    assign xe   = {bus.i_data[IW-1], bus.i_data};
    assign sum  = xe + (IW+1)'(HALF);
    // Dropping the low SH bits of a sign-extended word is the arithmetic shift.
    assign q_fl = {bus.i_data[IW-1], bus.i_data[IW-1:SH]};
    assign q_up = sum[IW:SH];
    assign tie  = (bus.i_data[SH-1:0] == HALF);
    assign unused_lo = ^sum[SH-1:0];

    always_comb begin
      q = q_fl;
      case (bus.i_qmode)
        2'd1:    q = q_up;
        // On an exact tie the rounded-up value is odd only when floor is even.
        2'd2:    q = (tie && q_up[0]) ? q_fl : q_up;
        default: q = q_fl;
      endcase
    end
  end

  // ---- overflow detect and wrap/saturate ----
  logic signed [EW-1:0] qe;
  logic                 ovf;
  logic [OW-1:0]        res;

  assign qe  = EW'(q);
  // In range iff all bits above the OW-bit sign agree with it.
  assign ovf = (qe[EW-1:OW-1] != {(EW-OW+1){qe[OW-1]}});
  assign res = (bus.i_omode && ovf) ? (qe[EW-1] ? MINV : MAXV) : qe[OW-1:0];

  // ---- pipeline ----
  stage_t           pipe [1:DELAY];
  logic [DELAY:1]   vld_pipe;
  logic             o_valid, en;

  assign o_valid = vld_pipe[DELAY];
  assign en      = bus.i_ready | ~o_valid;   // whole pipe moves as one

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= DELAY; k++) pipe[k] <= '0;
    end else if (en) begin
      vld_pipe[1] <= bus.i_valid;
      pipe[1]     <= '{data: res, ovf: ovf};
      for (int k = 2; k <= DELAY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        pipe[k]     <= pipe[k-1];
      end
    end
  end

  assign bus.o_ready = en;
  assign bus.o_valid = o_valid;
  assign bus.o_data  = pipe[DELAY].data;
  assign bus.o_ovf   = pipe[DELAY].ovf;

  // ---- overflow event counter ----
`ifdef FX_MATCH_OVF_CNT_EN
  logic [CNTW-1:0] ovf_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_clr)
      ovf_cnt <= '0;                         // clear beats a same-cycle increment
    else if (o_valid && bus.i_ready && pipe[DELAY].ovf && !(&ovf_cnt))
      ovf_cnt <= ovf_cnt + CNTW'(1);
  end

  assign bus.o_ovf_cnt = ovf_cnt;
`else
  logic unused_clr;
  assign unused_clr    = bus.i_clr;
  assign bus.o_ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_fx_match_pipe.sv
module tb_fx_match_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef FX_MATCH_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fx_match_pipe_if #(.IW(17), .OW(12), .CNTW(16)) b1 ();
  fx_match_pipe_if #(.IW(17), .OW(12), .CNTW(16)) b2 ();
  fx_match_pipe_if #(.IW(17), .OW(12), .CNTW(16)) b3 ();
  fx_match_pipe_if #(.IW(17), .OW(12), .CNTW(2))  bc ();

  fx_match_pipe #(.IW(17), .IF(2), .OW(12), .OF(0), .DELAY(1), .CNTW(16))
    dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
  fx_match_pipe #(.IW(17), .IF(2), .OW(12), .OF(0), .DELAY(2), .CNTW(16))
    dut2 (.i_clk(clk), .i_rst(rst), .bus(b2));
  fx_match_pipe #(.IW(17), .IF(2), .OW(12), .OF(0), .DELAY(3), .CNTW(16))
    dut3 (.i_clk(clk), .i_rst(rst), .bus(b3));
  fx_match_pipe #(.IW(17), .IF(2), .OW(12), .OF(0), .DELAY(1), .CNTW(2))
    dutc (.i_clk(clk), .i_rst(rst), .bus(bc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // single sample through dut1 (DELAY=1), idle cycle around it
  task automatic conv1(input logic [16:0] d, input logic [1:0] qm, input logic om,
                       input logic [11:0] ed, input logic eo, input string tag);
    @(negedge clk);
    b1.i_data = d; b1.i_qmode = qm; b1.i_omode = om; b1.i_valid = 1'b1;
    @(negedge clk);
    b1.i_valid = 1'b0;
    chk({tag, "_vld"},  32'(b1.o_valid), 32'd1);
    chk({tag, "_data"}, 32'(b1.o_data),  32'(ed));
    chk({tag, "_ovf"},  32'(b1.o_ovf),   32'(eo));
  endtask

  // per-sample mode vectors for dut2 (DELAY=2)
  logic [16:0] md [5] = '{17'd10, 17'd10, 17'd8192, 17'd8192, 17'd7};
  logic [1:0]  mq [5] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
  logic        mo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [11:0] me [5] = '{12'h003, 12'h002, 12'h7FF, 12'h800, 12'h001};
  logic        mv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int tx, rx, seen, e;
    logic held_v;
    logic [11:0] held_d;

    b1.i_data = '0; b1.i_valid = 0; b1.i_qmode = 0; b1.i_omode = 0; b1.i_ready = 1; b1.i_clr = 0;
    b2.i_data = '0; b2.i_valid = 0; b2.i_qmode = 0; b2.i_omode = 0; b2.i_ready = 1; b2.i_clr = 0;
    b3.i_data = '0; b3.i_valid = 0; b3.i_qmode = 0; b3.i_omode = 0; b3.i_ready = 1; b3.i_clr = 0;
    bc.i_data = '0; bc.i_valid = 0; bc.i_qmode = 0; bc.i_omode = 0; bc.i_ready = 1; bc.i_clr = 0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_vld",   32'(b1.o_valid),   32'd0);
    chk("rst_data",  32'(b1.o_data),    32'd0);
    chk("rst_ovf",   32'(b1.o_ovf),     32'd0);
    chk("rst_rdy",   32'(b1.o_ready),   32'd1);
    chk("rst_cnt",   32'(b1.o_ovf_cnt), 32'd0);
    chk("rst_vld3",  32'(b3.o_valid),   32'd0);

    // ---- rounding ----
    conv1(17'd7,      2'd0, 1'b0, 12'h001, 1'b0, "r7_tr");
    conv1(17'd7,      2'd1, 1'b0, 12'h002, 1'b0, "r7_rn");
    conv1(17'd7,      2'd2, 1'b0, 12'h002, 1'b0, "r7_cv");
    conv1(17'd7,      2'd3, 1'b0, 12'h001, 1'b0, "r7_m3");
    conv1(17'd6,      2'd0, 1'b0, 12'h001, 1'b0, "r6_tr");
    conv1(17'd6,      2'd1, 1'b0, 12'h002, 1'b0, "r6_rn");
    conv1(17'd6,      2'd2, 1'b0, 12'h002, 1'b0, "r6_cv");
    conv1(17'd10,     2'd0, 1'b0, 12'h002, 1'b0, "r10_tr");
    conv1(17'd10,     2'd1, 1'b0, 12'h003, 1'b0, "r10_rn");
    conv1(17'd10,     2'd2, 1'b0, 12'h002, 1'b0, "r10_cv");
    conv1(17'h1FFFD,  2'd0, 1'b0, 12'hFFF, 1'b0, "rn3_tr");
    conv1(17'h1FFFD,  2'd1, 1'b0, 12'hFFF, 1'b0, "rn3_rn");
    conv1(17'h1FFFD,  2'd2, 1'b0, 12'hFFF, 1'b0, "rn3_cv");
    conv1(17'h1FFFA,  2'd2, 1'b0, 12'hFFE, 1'b0, "rn6_cv");   // -1.5 -> -2
    conv1(17'h1FFFA,  2'd1, 1'b0, 12'hFFF, 1'b0, "rn6_rn");   // -1.5 -> -1

    // ---- overflow ----
    conv1(17'd8192,   2'd0, 1'b0, 12'h800, 1'b1, "o_pos_wr");
    conv1(17'd8192,   2'd0, 1'b1, 12'h7FF, 1'b1, "o_pos_sat");
    conv1(17'h1E000,  2'd0, 1'b0, 12'h800, 1'b0, "o_min_wr");
    conv1(17'h1E000,  2'd0, 1'b1, 12'h800, 1'b0, "o_min_sat");
    conv1(17'h1DFFC,  2'd0, 1'b0, 12'h7FF, 1'b1, "o_neg_wr");
    conv1(17'h1DFFC,  2'd0, 1'b1, 12'h800, 1'b1, "o_neg_sat");
    conv1(17'd8190,   2'd1, 1'b1, 12'h7FF, 1'b1, "o_rnd_sat"); // 2047.5 rounds to 2048

    // ---- per-sample modes, DELAY=2, back-to-back ----
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("pm_vld",  32'(b2.o_valid), 32'd1);
        chk("pm_data", 32'(b2.o_data),  32'(me[i-2]));
        chk("pm_ovf",  32'(b2.o_ovf),   32'(mv[i-2]));
      end
      if (i < 5) begin
        b2.i_data = md[i]; b2.i_qmode = mq[i]; b2.i_omode = mo[i]; b2.i_valid = 1'b1;
      end else begin
        b2.i_valid = 1'b0; b2.i_qmode = 2'd3; b2.i_omode = 1'b1;
      end
    end

    // ---- back-pressure, DELAY=3 ----
    tx = 0; rx = 0; held_v = 1'b0; held_d = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (held_v) begin
        chk("bp_hold_vld",  32'(b3.o_valid), 32'd1);
        chk("bp_hold_data", 32'(b3.o_data),  32'(held_d));
      end
      b3.i_ready = ((c / 2) % 2 == 0);
      b3.i_valid = (tx < 10);
      b3.i_data  = 17'(tx * 40 + 1);
      b3.i_qmode = 2'd0; b3.i_omode = 1'b0;
      #1;
      if (b3.i_ready)
        chk("bp_rdy_on", 32'(b3.o_ready), 32'd1);
      else if (b3.o_valid)
        chk("bp_rdy_stall", 32'(b3.o_ready), 32'd0);
      if (b3.o_valid && b3.i_ready) begin
        if (rx < 10) chk("bp_data", 32'(b3.o_data), 32'(rx * 10));
        rx++;
      end
      held_v = b3.o_valid && !b3.i_ready;
      held_d = b3.o_data;
      if (b3.i_valid && b3.o_ready) tx++;
    end
    chk("bp_tx", 32'(tx), 32'd10);
    chk("bp_rx", 32'(rx), 32'd10);

    // ---- reset flush, DELAY=3 ----
    b3.i_ready = 1'b1;
    @(negedge clk); b3.i_data = 17'd401; b3.i_valid = 1'b1;
    @(negedge clk); b3.i_data = 17'd405;
    @(negedge clk); b3.i_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("flush_vld", 32'(b3.o_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b3.o_valid) seen++;
    end
    chk("flush_stale", 32'(seen), 32'd0);

    // ---- overflow counter, CNTW=2 ----
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      e = (j < 1) ? 0 : ((j - 1 > 3) ? 3 : j - 1);
      chk("cnt_sat", 32'(bc.o_ovf_cnt), CNT_EN ? 32'(e) : 32'd0);
      bc.i_data = 17'd8192; bc.i_qmode = 2'd0; bc.i_omode = 1'b0;
      bc.i_valid = (j < 5);
    end
    @(negedge clk); bc.i_clr = 1'b1;
    @(negedge clk); bc.i_clr = 1'b0;
    chk("cnt_clr", 32'(bc.o_ovf_cnt), 32'd0);
    @(negedge clk); bc.i_valid = 1'b1;
    @(negedge clk); bc.i_valid = 1'b0;
    @(negedge clk);
    chk("cnt_one", 32'(bc.o_ovf_cnt), CNT_EN ? 32'd1 : 32'd0);
    @(negedge clk); bc.i_valid = 1'b1;
    @(negedge clk); bc.i_valid = 1'b0; bc.i_clr = 1'b1;
    chk("cnt_pre_ovf", 32'(bc.o_ovf), 32'd1);
    @(negedge clk); bc.i_clr = 1'b0;
    chk("cnt_clr_inc", 32'(bc.o_ovf_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
